// File: rtl/acc_sequencer.sv
// acc_sequencer: AC/DR/E register stage wrapped around the 16-bit ALU.
// Sequences one instruction per start pulse through IDLE -> ISSUE -> CAPTURE.
// ALU ops 0-7 are captured from the external ALU. Register-reference ops 8-15
// are executed locally. done/skip are reported as registered one-cycle pulses.
module acc_sequencer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] bus_in,
  input  logic         ld_ac,
  input  logic         ld_dr,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] alu_out,
  input  logic         alu_eo,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_opcode,
  output logic         alu_ei,
  output logic [W-1:0] ac_out,
  output logic         e_out,
  output logic         busy,
  output logic         done,
  output logic         skip
);

  localparam int unsigned OP_W  = 4;
  localparam int unsigned AOP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_INC = 4'd2;
  localparam logic [OP_W-1:0] OP_DEC = 4'd3;
  localparam logic [OP_W-1:0] OP_AND = 4'd4;
  localparam logic [OP_W-1:0] OP_OR  = 4'd5;
  localparam logic [OP_W-1:0] OP_XOR = 4'd6;
  localparam logic [OP_W-1:0] OP_CMA = 4'd7;
  localparam logic [OP_W-1:0] OP_CLA = 4'd8;
  localparam logic [OP_W-1:0] OP_CLE = 4'd9;
  localparam logic [OP_W-1:0] OP_CME = 4'd10;
  localparam logic [OP_W-1:0] OP_CIR = 4'd11;
  localparam logic [OP_W-1:0] OP_CIL = 4'd12;
  localparam logic [OP_W-1:0] OP_SPA = 4'd13;
  localparam logic [OP_W-1:0] OP_SNA = 4'd14;
  localparam logic [OP_W-1:0] OP_SZA = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [W-1:0]       ac_q, ac_d;
  logic [W-1:0]       dr_q, dr_d;
  logic               e_q, e_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [AOP_W-1:0]   aop_q, aop_d;
  logic               done_q, done_d;
  logic               skip_q, skip_d;

  // Result of the latched op, computed from the current AC/E and the ALU
  logic [W-1:0]       exec_ac;
  logic               exec_e;
  logic               exec_skip;

  // Per-op result selection used on the CAPTURE -> IDLE edge
  always_comb begin
    exec_ac   = ac_q;
    exec_e    = e_q;
    exec_skip = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
        exec_ac = alu_out;
        exec_e  = alu_eo;
      end
      OP_AND, OP_OR, OP_XOR, OP_CMA: begin
        exec_ac = alu_out;
      end
      OP_CLA: exec_ac = '0;
      OP_CLE: exec_e  = 1'b0;
      OP_CME: exec_e  = ~e_q;
      OP_CIR: begin
        exec_ac = {e_q, ac_q[W-1:1]};
        exec_e  = ac_q[0];
      end
      OP_CIL: begin
        exec_ac = {ac_q[W-2:0], e_q};
        exec_e  = ac_q[W-1];
      end
      OP_SPA: exec_skip = ~ac_q[W-1];
      OP_SNA: exec_skip = ac_q[W-1];
      OP_SZA: exec_skip = (ac_q == '0);
      default: begin
        exec_ac   = ac_q;
        exec_e    = e_q;
        exec_skip = 1'b0;
      end
    endcase
  end

  // Next-state and register updates; loads only land while idle
  always_comb begin
    state_d = state_q;
    ac_d    = ac_q;
    dr_d    = dr_q;
    e_d     = e_q;
    op_d    = op_q;
    aop_d   = aop_q;
    done_d  = 1'b0;
    skip_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // start beats ld_ac, but a coincident ld_dr feeds the new operand
          state_d = S_ISSUE;
          op_d    = op;
          aop_d   = op[AOP_W-1:0];
          if (ld_dr) dr_d = bus_in;
        end else begin
          if (ld_ac) ac_d = bus_in;
          if (ld_dr) dr_d = bus_in;
        end
      end
      S_ISSUE: begin
        // ALU operands are stable from registers this cycle
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_d = S_IDLE;
        ac_d    = exec_ac;
        e_d     = exec_e;
        done_d  = 1'b1;
        skip_d  = exec_skip;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ac_q    <= '0;
      dr_q    <= '0;
      e_q     <= 1'b0;
      op_q    <= '0;
      aop_q   <= '0;
      done_q  <= 1'b0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ac_q    <= ac_d;
      dr_q    <= dr_d;
      e_q     <= e_d;
      op_q    <= op_d;
      aop_q   <= aop_d;
      done_q  <= done_d;
      skip_q  <= skip_d;
    end
  end

  assign alu_a      = ac_q;
  assign ac_out     = ac_q;
  assign alu_b      = dr_q;
  assign alu_ei     = e_q;
  assign e_out      = e_q;
  assign alu_opcode = aop_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign skip       = skip_q;

endmodule

// File: tb/tb_acc_sequencer.sv
// Scoreboard bench for acc_sequencer: a stimulus process pushes expected
// results computed from an arithmetic reference model, a monitor pops them
// whenever done is seen.
module tb_acc_sequencer;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] bus_in = '0;
  logic         ld_ac = 1'b0;
  logic         ld_dr = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] alu_out;
  logic         alu_eo;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_opcode;
  logic         alu_ei;
  logic [W-1:0] ac_out;
  logic         e_out;
  logic         busy;
  logic         done;
  logic         skip;

  acc_sequencer #(.W(W)) dut (
    .clk(clk), .rst(rst), .bus_in(bus_in), .ld_ac(ld_ac), .ld_dr(ld_dr),
    .start(start), .op(op), .alu_out(alu_out), .alu_eo(alu_eo),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_ei(alu_ei),
    .ac_out(ac_out), .e_out(e_out), .busy(busy), .done(done), .skip(skip)
  );

  always #5 clk = ~clk;

  // Combinational ALU sitting next to the DUT
  logic [W:0] alu_wide;
  always_comb begin
    alu_wide = '0;
    case (alu_opcode)
      3'd0: alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: alu_wide = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
      3'd2: alu_wide = {1'b0, alu_a} + 17'd1;
      3'd3: alu_wide = {1'b0, alu_a} + {1'b0, 16'hFFFF};
      3'd4: alu_wide = {1'b0, alu_a & alu_b};
      3'd5: alu_wide = {1'b0, alu_a | alu_b};
      3'd6: alu_wide = {1'b0, alu_a ^ alu_b};
      3'd7: alu_wide = {1'b0, ~alu_a};
      default: alu_wide = '0;
    endcase
  end
  assign alu_out = alu_wide[W-1:0];
  assign alu_eo  = alu_wide[W];

  typedef struct {
    logic [15:0] ac;
    logic        e;
    logic        sk;
    int unsigned cyc;
    int unsigned opc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_x;
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  // Reference state
  int unsigned m_ac = 0;
  int unsigned m_dr = 0;
  bit          m_e = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic flag(input string name, input string what);
    n_checks++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    start = 1'b0; ld_ac = 1'b0; ld_dr = 1'b0;
    bus_in = '0; op = '0;
  endtask

  task automatic drive_noise(input bit noise);
    if (noise) begin
      start  = 1'($urandom % 2);
      ld_ac  = 1'($urandom % 2);
      ld_dr  = 1'($urandom % 2);
      bus_in = 16'($urandom);
      op     = 4'($urandom);
    end else begin
      drive_idle();
    end
  endtask

  // Architectural effect of one instruction, straight from the op table
  task automatic model_exec(input int unsigned opc, output logic [15:0] ac_o,
                            output logic e_o, output logic sk_o);
    int unsigned a;
    int unsigned b;
    bit sk;
    a  = m_ac;
    b  = m_dr;
    sk = 1'b0;
    case (opc)
      0:  begin m_ac = (a + b) % 65536; m_e = (a + b) > 65535; end
      1:  begin m_ac = (a + 65536 - b) % 65536; m_e = (a >= b); end
      2:  begin m_ac = (a + 1) % 65536; m_e = (a == 65535); end
      3:  begin m_ac = (a + 65535) % 65536; m_e = (a != 0); end
      4:  m_ac = a & b;
      5:  m_ac = a | b;
      6:  m_ac = a ^ b;
      7:  m_ac = 65535 - a;
      8:  m_ac = 0;
      9:  m_e = 1'b0;
      10: m_e = !m_e;
      11: begin m_ac = a / 2 + (m_e ? 32768 : 0); m_e = (a % 2) == 1; end
      12: begin m_ac = (a * 2) % 65536 + (m_e ? 1 : 0); m_e = a >= 32768; end
      13: sk = (a < 32768);
      14: sk = (a >= 32768);
      15: sk = (a == 0);
      default: sk = 1'b0;
    endcase
    ac_o = 16'(m_ac);
    e_o  = m_e;
    sk_o = sk;
  endtask

  task automatic do_load(input bit la, input bit ld, input logic [15:0] v);
    start = 1'b0; ld_ac = la; ld_dr = ld; bus_in = v;
    if (la) m_ac = 32'(v);
    if (ld) m_dr = 32'(v);
    step();
    drive_idle();
  endtask

  // Issue one op; returns in the cycle done is expected high
  task automatic do_op(input int unsigned opc, input bit with_dr, input bit with_ac,
                       input logic [15:0] v, input bit noise);
    exp_t x;
    start = 1'b1; op = 4'(opc); ld_dr = with_dr; ld_ac = with_ac; bus_in = v;
    if (with_dr) m_dr = 32'(v);
    x.cyc = cyc + 3;
    x.opc = opc;
    model_exec(opc, x.ac, x.e, x.sk);
    sb.push_back(x);
    step();
    check("opcode_issue", 32'(alu_opcode), 32'(opc % 8));
    check("busy_issue", 32'(busy), 32'd1);
    check("alu_b_issue", 32'(alu_b), m_dr);
    drive_noise(noise);
    step();
    check("busy_capture", 32'(busy), 32'd1);
    drive_noise(noise);
    step();
    check("busy_after", 32'(busy), 32'd0);
    drive_idle();
  endtask

  // Monitor: compare every done pulse against the scoreboard head
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (sb.size() == 0) begin
          flag("unexpected_done", "done with empty scoreboard");
        end else begin
          mon_x = sb.pop_front();
          check("done_cycle", cyc, mon_x.cyc);
          check("ac_out", 32'(ac_out), 32'(mon_x.ac));
          check("e_out", 32'(e_out), 32'(mon_x.e));
          check("skip", 32'(skip), 32'(mon_x.sk));
        end
      end else begin
        if (skip) flag("skip_without_done", "skip high while done low");
        if (sb.size() != 0 && cyc > sb[0].cyc) begin
          flag("done_timeout", $sformatf("op %0d never completed", sb[0].opc));
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    drive_idle();
    rst = 1'b1;
    step(); step(); step();
    check("rst_ac", 32'(ac_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    step();
    check("idle_ac", 32'(ac_out), 32'd0);
    check("idle_e", 32'(e_out), 32'd0);
    check("idle_b", 32'(alu_b), 32'd0);
    check("idle_opcode", 32'(alu_opcode), 32'd0);
    check("idle_skip", 32'(skip), 32'd0);

    // ADD 3 + 4
    do_load(1'b1, 1'b0, 16'h0003);
    do_load(1'b0, 1'b1, 16'h0004);
    do_op(0, 1'b0, 1'b0, 16'h0000, 1'b0);
    // INC wraps
    do_load(1'b1, 1'b0, 16'hFFFF);
    do_op(2, 1'b0, 1'b0, 16'h0000, 1'b0);
    // Rotate through E
    do_load(1'b1, 1'b0, 16'h8001);
    do_op(9, 1'b0, 1'b0, 16'h0000, 1'b0);
    do_op(12, 1'b0, 1'b0, 16'h0000, 1'b0);
    do_op(11, 1'b0, 1'b0, 16'h0000, 1'b0);
    // Skips
    do_load(1'b1, 1'b0, 16'h0000);
    do_op(15, 1'b0, 1'b0, 16'h0000, 1'b0);
    do_load(1'b1, 1'b0, 16'h8000);
    do_op(13, 1'b0, 1'b0, 16'h0000, 1'b0);
    do_op(14, 1'b0, 1'b0, 16'h0000, 1'b0);
    do_op(0, 1'b0, 1'b0, 16'h0000, 1'b0);
    // Collisions
    do_load(1'b1, 1'b0, 16'h0005);
    do_op(0, 1'b1, 1'b0, 16'h0010, 1'b0);
    do_op(5, 1'b0, 1'b1, 16'h7777, 1'b0);
    do_load(1'b1, 1'b1, 16'h0A0A);
    do_op(1, 1'b0, 1'b0, 16'h0000, 1'b1);
    do_op(10, 1'b0, 1'b0, 16'h0000, 1'b1);

    // Reset in the middle of an op
    do_load(1'b1, 1'b0, 16'h1234);
    start = 1'b1; op = 4'd0;
    step();
    drive_idle();
    #1 rst = 1'b1;
    #1;
    m_ac = 0; m_dr = 0; m_e = 1'b0;
    check("midrst_ac", 32'(ac_out), 32'd0);
    check("midrst_e", 32'(e_out), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("midrst_no_done", 32'(done), 32'd0);
      step();
    end
    check("post_rst_ac", 32'(ac_out), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 250; i++) begin
      if ($urandom % 3 == 0) begin
        int unsigned sel;
        sel = 1 + ($urandom % 3);
        do_load(sel[0], sel[1], 16'($urandom));
      end
      for (int g = 0; g < int'($urandom % 3); g++) step();
      do_op($urandom % 16, ($urandom % 4) == 0, ($urandom % 4) == 0,
            16'($urandom), ($urandom % 2) == 1);
    end

    for (int i = 0; i < 6; i++) step();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
